mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped serial output port that sits downstream of the single-cycle MIPS core in top. It snoops the data-memory store bus (memwrite, dataadr, writedata) in parallel with dmem. Stores to its data address queue a byte into a small FIFO. A UART transmitter drains the FIFO as 8N1 frames, giving programs a console output without stalling the core.

Parameters:
DATA_ADDR, 32'h0000_00F0, byte address whose stores push writedata[7:0] into the FIFO
CTRL_ADDR, 32'h0000_00F4, byte address whose stores with writedata[0]=1 clear the overflow flag
DEPTH, 4, FIFO entries; power of two, >=2
CLKS_PER_BIT, 16, clk cycles per serial bit; >=2

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
memwrite  in  1  store strobe from core, same cycle as dataadr/writedata
dataadr  in  32  store byte address (core ALU output)
writedata  in  32  store data
tx  out  1  serial line, idle high
busy  out  1  1 while a frame is in progress (state != IDLE)
fifo_count  out  clog2(DEPTH)+1  number of queued bytes, not counting the byte being shifted
overflow  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at posedge) puts the block in IDLE, empties the FIFO (pointers and count 0), sets tx=1, busy=0, overflow=0 and clears the baud and bit counters. Reset wins over every other event. A frame in progress when reset is asserted is aborted, and tx is 1 after that edge.
- Address decode is a full 32-bit equality compare. No other address has any effect.
- Push: memwrite=1 and dataadr==DATA_ADDR at a posedge.
  - The push is accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1. FIFO contents are unchanged.
- Clear: memwrite=1, dataadr==CTRL_ADDR and writedata[0]=1 clears overflow. If a drop occurs in the same cycle, overflow stays set (set wins).
- Pop: happens whenever the FSM loads the shift register (see below). The FIFO is first-in first-out, with read/write pointers wrapping modulo DEPTH.
- Simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1, and each bit period is CLKS_PER_BIT cycles.
  - IDLE: tx=1. If fifo_count>0, pop the head into the 8-bit shift register, go to START and set baud=0.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At the end of each bit period, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for one bit period. At its end, if fifo_count>0 (sampled that cycle), pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: a store accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx falls low after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is driven from a register (glitch-free). busy is 1 in START, DATA and STOP.
- Stores to DATA_ADDR during a frame queue normally. The byte being shifted is not counted in fifo_count.

Test Plan:
- Reset: hold reset=0 for 3 cycles, with memwrite pulses to DATA_ADDR during reset -> tx=1, busy=0, fifo_count=0, overflow=0; no frame follows.
- Single byte, CLKS_PER_BIT=4: store 32'h0000_0155 to 32'hF0 at edge N -> tx=0 for cycles N+1..N+4. Data bits 1,0,1,0,1,0,1,0 follow, 4 cycles each, then stop high 4 cycles. busy drops at edge N+41. fifo_count returns to 0 at edge N+1.
- Back-to-back: store 8'h41, 8'h42, 8'h43 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap, bytes in order 41,42,43. fifo_count peaks at 2.
- Overflow: with DEPTH=4, make 6 rapid stores while the first frame is active -> 5 queued-or-shifting bytes transmitted and overflow=1. Then store 1 to 32'hF4 -> overflow=0.
- Full with simultaneous pop: fill the FIFO to 4, then store exactly at the STOP->START pop edge -> push accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 next edge, FIFO empty. A new store afterwards transmits a clean frame.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Store-bus snooping console port: stores to DATA_ADDR queue bytes in a small
// FIFO that is drained as 8N1 serial frames on tx; CTRL_ADDR clears overflow.
module mmio_uart_tx #(
  parameter logic [31:0] DATA_ADDR    = 32'h0000_00F0,
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_00F4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic push_req;
  logic clr_req;
  logic bit_end;
  logic pop;
  logic push;
  logic unused_wdata;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    push_req     = memwrite && (dataadr == DATA_ADDR);
    clr_req      = memwrite && (dataadr == CTRL_ADDR) && writedata[0];
    bit_end      = (baud == BAUD_LAST);
    pop          = (fifo_count != '0) &&
                   ((state == IDLE) || ((state == STOP) && bit_end));
    push         = push_req && ((fifo_count != FULL) || pop);
    unused_wdata = ^writedata[31:8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (push_req && !push) overflow <= 1'b1;
      else if (clr_req)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[7:0];
  end

  // tx and busy are registered and always loaded with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, DEPTH=4; every bit of
// every frame is compared against hand-derived 8N1 waveforms.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mmio_uart_tx #(
    .DATA_ADDR   (32'h0000_00F0),
    .CTRL_ADDR   (32'h0000_00F4),
    .DEPTH       (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic clear_bus();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  // k counts cycles from the edge where tx fell for the start bit
  task automatic check_frame(input logic [7:0] b, input int first, input int last);
    logic exp_bit;
    for (int k = first; k <= last; k++) begin
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = b[(k - 4) / 4];
      else             exp_bit = 1'b1;
      check($sformatf("tx_%02h_k%0d", b, k), tx, exp_bit);
      check($sformatf("busy_%02h_k%0d", b, k), busy, 1'b1);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_count"}, fifo_count, 3'd0);
  endtask

  initial begin
    reset = 1'b0;
    clear_bus();

    // Reset with stores attempted during reset
    for (int i = 0; i < 3; i++) begin
      set_store(32'hF0, 32'hA5 + i);
      tick();
    end
    clear_bus();
    check_idle("rst");
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("rst_quiet");
    end

    // Single byte
    set_store(32'hF0, 32'h0000_0155);
    tick();
    clear_bus();
    check("single_count_n", fifo_count, 3'd1);
    check("single_tx_n", tx, 1'b1);
    check("single_busy_n", busy, 1'b0);
    tick();
    check("single_count_n1", fifo_count, 3'd0);
    check_frame(8'h55, 0, 39);
    check_idle("single_end");

    // Back-to-back frames
    set_store(32'hF0, 32'h41);
    tick();
    check("b2b_count_n", fifo_count, 3'd1);
    set_store(32'hF0, 32'h42);
    tick();
    check("b2b_tx_start", tx, 1'b0);
    check("b2b_count_n1", fifo_count, 3'd1);
    set_store(32'hF0, 32'h43);
    tick();
    clear_bus();
    check("b2b_count_peak", fifo_count, 3'd2);
    check_frame(8'h41, 1, 39);
    check("b2b_count_f2", fifo_count, 3'd1);
    check_frame(8'h42, 0, 39);
    check("b2b_count_f3", fifo_count, 3'd0);
    check_frame(8'h43, 0, 39);
    check_idle("b2b_end");

    // Overflow: six rapid stores, the sixth is dropped
    set_store(32'hF0, 32'h11); tick();
    set_store(32'hF0, 32'h22); tick();
    set_store(32'hF0, 32'h33); tick();
    set_store(32'hF0, 32'h44); tick();
    set_store(32'hF0, 32'h55); tick();
    check("ovf_count_full", fifo_count, 3'd4);
    check("ovf_flag_pre", overflow, 1'b0);
    set_store(32'hF0, 32'h66); tick();
    clear_bus();
    check("ovf_count_drop", fifo_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check_frame(8'h11, 4, 39);
    check("ovf_count_f2", fifo_count, 3'd3);
    check_frame(8'h22, 0, 39);
    check_frame(8'h33, 0, 39);
    check_frame(8'h44, 0, 39);
    check_frame(8'h55, 0, 39);
    check_idle("ovf_end");
    check("ovf_sticky", overflow, 1'b1);
    set_store(32'hF4, 32'h0000_0000); tick(); clear_bus();
    check("ovf_clr_bit0_zero", overflow, 1'b1);
    set_store(32'hF8, 32'h0000_0001); tick(); clear_bus();
    check("ovf_clr_wrong_addr", overflow, 1'b1);
    set_store(32'hF4, 32'h0000_0001); tick(); clear_bus();
    check("ovf_clr", overflow, 1'b0);
    check("ctrl_no_push", fifo_count, 3'd0);

    // Full 32-bit address decode: aliases must not push
    set_store(32'h0000_01F0, 32'hAA); tick();
    set_store(32'h8000_00F0, 32'hAA); tick(); clear_bus();
    check("alias_no_push", fifo_count, 3'd0);
    tick();
    check_idle("alias_quiet");

    // Full FIFO with a push on the STOP->START pop edge
    set_store(32'hF0, 32'h81); tick();
    set_store(32'hF0, 32'h7E); tick();
    set_store(32'hF0, 32'hC3); tick();
    set_store(32'hF0, 32'h3C); tick();
    set_store(32'hF0, 32'h0F); tick();
    clear_bus();
    check("full_count", fifo_count, 3'd4);
    check_frame(8'h81, 3, 38);
    check("full_stop_tx", tx, 1'b1);
    set_store(32'hF0, 32'hF0);
    tick();
    clear_bus();
    check("full_pop_count", fifo_count, 3'd4);
    check("full_pop_ovf", overflow, 1'b0);
    check_frame(8'h7E, 0, 39);
    check_frame(8'hC3, 0, 39);
    check_frame(8'h3C, 0, 39);
    check_frame(8'h0F, 0, 39);
    check_frame(8'hF0, 0, 39);
    check_idle("full_end");
    check("full_end_ovf", overflow, 1'b0);

    // Reset during DATA bit 3 with a byte still queued
    set_store(32'hF0, 32'h96); tick();
    set_store(32'hF0, 32'h5A); tick();
    clear_bus();
    check("mid_count", fifo_count, 3'd1);
    check_frame(8'h96, 0, 17);
    reset = 1'b0;
    tick();
    check_idle("mid_rst");
    check("mid_rst_ovf", overflow, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("mid_quiet");
    end
    set_store(32'hF0, 32'h3C); tick(); clear_bus();
    tick();
    check_frame(8'h3C, 0, 39);
    check_idle("mid_new_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
